// File: rtl/rsa_keygen_if.sv
// Request/status handshake and published key set of the RSA key-generation sequencer.
interface rsa_keygen_if;
    logic        start;
    logic [11:0] prime_p;
    logic [11:0] prime_q;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] key_p;
    logic [11:0] key_q;
    logic [23:0] key_n;
    logic [23:0] key_totient;
    logic [23:0] key_e;

    modport master (
        output start, prime_p, prime_q,
        input  busy, done, err, key_p, key_q, key_n, key_totient, key_e
    );

    modport slave (
        input  start, prime_p, prime_q,
        output busy, done, err, key_p, key_q, key_n, key_totient, key_e
    );
endinterface

// File: rtl/rsa_keygen_ctrl.sv
// RSA key-generation sequencer: samples a prime pair, forms n and the totient on one
// shift-add multiplier, then searches the smallest odd e coprime to the totient with a
// Euclid loop built on a restoring divider. One registered key set per successful run.
//
// | state  | meaning
// | IDLE   | waiting for start
// | SAMPLE | capture prime pair, reject unusable pairs, count retries
// | MUL_N  | 12-cycle shift-add p*q
// | MUL_T  | 12-cycle shift-add (p-1)*(q-1)
// | E_INIT | first candidate e, dividend = totient, divisor = e
// | MOD    | 24-cycle restoring division, remainder only
// | STEP   | Euclid decision on the remainder
// | E_NEXT | next odd candidate e
// | DONE   | key set published (or retry error), done pulse
module rsa_keygen_ctrl #(
    parameter int unsigned E_START   = 3,
    parameter int unsigned MAX_RETRY = 15
) (
    input  logic        clk,
    input  logic        rst,
    rsa_keygen_if.slave kg
);
    typedef enum logic [3:0] {
        IDLE, SAMPLE, MUL_N, MUL_T, E_INIT, MOD, STEP, E_NEXT, DONE
    } state_t;

    localparam logic [3:0]  RETRY_LAST = 4'(MAX_RETRY - 1);
    localparam logic [23:0] E_FIRST    = 24'(E_START);

    state_t      state_q, state_d;
    logic [11:0] p_q, p_d, q_q, q_d;
    logic [23:0] n_q, n_d, tot_q, tot_d, e_q, e_d;
    logic [23:0] mcand_q, mcand_d;
    logic [11:0] mplier_q, mplier_d;
    logic [23:0] acc_q, acc_d;
    logic [23:0] div_a_q, div_a_d;
    logic [23:0] div_b_q, div_b_d;
    logic [23:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        done_q, done_d, err_q, err_d;
    logic [11:0] key_p_q, key_p_d, key_q_q, key_q_d;
    logic [23:0] key_n_q, key_n_d, key_tot_q, key_tot_d, key_e_q, key_e_d;
    logic        busy_o;

    logic        pair_bad;
    logic        cnt_tc;
    logic [23:0] acc_sum;
    logic [24:0] rem_sh;
    logic [23:0] rem_sub;
    logic        rem_fits;

    // Shared arithmetic terms: pair screening, multiplier add, divider trial subtract.
    always_comb begin
        pair_bad = (kg.prime_p == kg.prime_q) || (kg.prime_p < 12'd3) || (kg.prime_q < 12'd3);
        cnt_tc   = (cnt_q == 5'd0);
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : 24'd0);
        rem_sh   = {rem_q, div_a_q[23]};
        rem_fits = (rem_sh >= {1'b0, div_b_q});
        rem_sub  = rem_sh[23:0] - div_b_q;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (kg.start) state_d = SAMPLE;
            SAMPLE: begin
                if (!pair_bad)                 state_d = MUL_N;
                else if (retry_q == RETRY_LAST) state_d = DONE;
            end
            MUL_N:   if (cnt_tc) state_d = MUL_T;
            MUL_T:   if (cnt_tc) state_d = E_INIT;
            E_INIT:  state_d = MOD;
            MOD:     if (cnt_tc) state_d = STEP;
            STEP: begin
                if (rem_q != 24'd0)       state_d = MOD;
                else if (div_b_q == 24'd1) state_d = DONE;
                else                      state_d = E_NEXT;
            end
            E_NEXT:  state_d = MOD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: busy from the state, done/err/key registers loaded on entry to DONE.
    always_comb begin
        busy_o    = (state_q != IDLE);
        done_d    = (state_d == DONE);
        err_d     = (state_q == SAMPLE) && (state_d == DONE);
        key_p_d   = key_p_q;
        key_q_d   = key_q_q;
        key_n_d   = key_n_q;
        key_tot_d = key_tot_q;
        key_e_d   = key_e_q;
        if ((state_q == STEP) && (state_d == DONE)) begin
            key_p_d   = p_q;
            key_q_d   = q_q;
            key_n_d   = n_q;
            key_tot_d = tot_q;
            key_e_d   = e_q;
        end
    end

    // Working datapath: sample registers, multiplier, divider and Euclid operands.
    always_comb begin
        p_d      = p_q;
        q_d      = q_q;
        n_d      = n_q;
        tot_d    = tot_q;
        e_d      = e_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        div_a_d  = div_a_q;
        div_b_d  = div_b_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        unique case (state_q)
            IDLE: if (kg.start) retry_d = 4'd0;
            SAMPLE: begin
                p_d = kg.prime_p;
                q_d = kg.prime_q;
                if (pair_bad) begin
                    retry_d = retry_q + 4'd1;
                end else begin
                    mcand_d  = {12'd0, kg.prime_p};
                    mplier_d = kg.prime_q;
                    acc_d    = 24'd0;
                    cnt_d    = 5'd11;
                end
            end
            MUL_N, MUL_T: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 5'd1;
                if (cnt_tc && (state_q == MUL_N)) begin
                    // Reload the same multiplier for (p-1)*(q-1).
                    n_d      = acc_sum;
                    mcand_d  = {12'd0, p_q - 12'd1};
                    mplier_d = q_q - 12'd1;
                    acc_d    = 24'd0;
                    cnt_d    = 5'd11;
                end else if (cnt_tc) begin
                    tot_d = acc_sum;
                end
            end
            E_INIT: begin
                e_d     = E_FIRST;
                div_a_d = tot_q;
                div_b_d = E_FIRST;
                rem_d   = 24'd0;
                cnt_d   = 5'd23;
            end
            MOD: begin
                rem_d   = rem_fits ? rem_sub : rem_sh[23:0];
                div_a_d = div_a_q << 1;
                cnt_d   = cnt_q - 5'd1;
            end
            STEP: begin
                if (rem_q != 24'd0) begin
                    div_a_d = div_b_q;
                    div_b_d = rem_q;
                    rem_d   = 24'd0;
                    cnt_d   = 5'd23;
                end
            end
            E_NEXT: begin
                e_d     = e_q + 24'd2;
                div_a_d = tot_q;
                div_b_d = e_q + 24'd2;
                rem_d   = 24'd0;
                cnt_d   = 5'd23;
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset abandons any run without publishing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q       <= '0;
            q_q       <= '0;
            n_q       <= '0;
            tot_q     <= '0;
            e_q       <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            div_a_q   <= '0;
            div_b_q   <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            retry_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            key_p_q   <= '0;
            key_q_q   <= '0;
            key_n_q   <= '0;
            key_tot_q <= '0;
            key_e_q   <= '0;
        end else begin
            p_q       <= p_d;
            q_q       <= q_d;
            n_q       <= n_d;
            tot_q     <= tot_d;
            e_q       <= e_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            div_a_q   <= div_a_d;
            div_b_q   <= div_b_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            done_q    <= done_d;
            err_q     <= err_d;
            key_p_q   <= key_p_d;
            key_q_q   <= key_q_d;
            key_n_q   <= key_n_d;
            key_tot_q <= key_tot_d;
            key_e_q   <= key_e_d;
        end
    end

    assign kg.busy        = busy_o;
    assign kg.done        = done_q;
    assign kg.err         = err_q;
    assign kg.key_p       = key_p_q;
    assign kg.key_q       = key_q_q;
    assign kg.key_n       = key_n_q;
    assign kg.key_totient = key_tot_q;
    assign kg.key_e       = key_e_q;
endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// Bench for rsa_keygen_ctrl: a key-level model (plain %, *, gcd loop) predicts the key set
// and the done cycle of each run; a per-cycle compare checks every output against it, and
// hand-computed literals pin a few runs.
module tb_rsa_keygen_ctrl;
    localparam int MAX_RETRY = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rsa_keygen_if kg();

    rsa_keygen_ctrl #(.E_START(3), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk),
        .rst(rst),
        .kg (kg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Prime pair presented in each SAMPLE cycle of the current run.
    int seq_p[16];
    int seq_q[16];

    // Model of the current run (written by the stimulus process only).
    bit          armed      = 1'b0;
    int          launch     = 0;
    int          done_cyc_m = -100;
    bit          m_err      = 1'b0;
    logic [23:0] m_p = '0, m_q = '0, m_n = '0, m_tot = '0, m_e = '0;
    int          lit_cyc    = -1;
    bit          lit_err    = 1'b0;
    logic [23:0] lit_p = '0, lit_q = '0, lit_n = '0, lit_tot = '0, lit_e = '0;

    // Compare-process state.
    logic [23:0] pub_p = '0, pub_q = '0, pub_n = '0, pub_tot = '0, pub_e = '0;
    bit          e_busy, e_done;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Key-level prediction: which sample is accepted, the key set, and the cycle count.
    task automatic model_compute(input int start_cyc);
        int  s, p, q, a, b, r, e, k, nx, lat;
        bit  ok;
        s = 0; ok = 1'b0; m_err = 1'b0; p = 0; q = 0;
        while (!ok && !m_err && s < 16) begin
            p = seq_p[s];
            q = seq_q[s];
            s++;
            if (p == q || p < 3 || q < 3) begin
                if (s == MAX_RETRY) m_err = 1'b1;
            end else begin
                ok = 1'b1;
            end
        end
        if (ok) begin
            m_p = 24'(p); m_q = 24'(q);
            m_n = 24'(p * q);
            m_tot = 24'((p - 1) * (q - 1));
            e = 3; k = 0; nx = 0;
            forever begin
                a = (p - 1) * (q - 1);
                b = e;
                do begin
                    r = a % b;
                    k++;
                    if (r != 0) begin a = b; b = r; end
                end while (r != 0);
                if (b == 1) break;
                e += 2;
                nx++;
            end
            m_e = 24'(e);
            lat = 1 + s + 24 + 1 + 25 * k + nx + 1;
        end else begin
            lat = 1 + s + 1;
        end
        launch     = start_cyc;
        done_cyc_m = start_cyc + lat - 2;
    endtask

    // Per-cycle comparison against the model, plus literal pins at the expected done cycle.
    always @(negedge clk) begin
        if (rst) begin
            pub_p = '0; pub_q = '0; pub_n = '0; pub_tot = '0; pub_e = '0;
            chk("rst_busy", kg.busy, 0);
            chk("rst_done", kg.done, 0);
            chk("rst_err",  kg.err,  0);
            chk("rst_keys", {8'd0, kg.key_n | kg.key_totient | kg.key_e
                             | {12'd0, kg.key_p} | {12'd0, kg.key_q}}, 0);
        end else begin
            e_busy = armed && cyc >= launch && cyc <= done_cyc_m;
            e_done = armed && cyc == done_cyc_m;
            if (e_done && !m_err) begin
                pub_p = m_p; pub_q = m_q; pub_n = m_n; pub_tot = m_tot; pub_e = m_e;
            end
            chk("busy",        kg.busy, e_busy);
            chk("done",        kg.done, e_done);
            chk("err",         kg.err,  e_done && m_err);
            chk("key_p",       kg.key_p, pub_p);
            chk("key_q",       kg.key_q, pub_q);
            chk("key_n",       kg.key_n, pub_n);
            chk("key_totient", kg.key_totient, pub_tot);
            chk("key_e",       kg.key_e, pub_e);
            if (armed && cyc == lit_cyc) begin
                chk("model_latency", done_cyc_m, lit_cyc);
                chk("lit_done", kg.done, 1);
                chk("lit_err",  kg.err, lit_err);
                chk("lit_p",    kg.key_p, lit_p);
                chk("lit_q",    kg.key_q, lit_q);
                chk("lit_n",    kg.key_n, lit_n);
                chk("lit_tot",  kg.key_totient, lit_tot);
                chk("lit_e",    kg.key_e, lit_e);
            end
        end
    end

    // Prime generator: sequence values during the run's sample window, noise elsewhere.
    initial begin
        kg.prime_p = 12'd0;
        kg.prime_q = 12'd0;
        forever begin
            @(negedge clk);
            if (armed && cyc >= launch && (cyc - launch) < 16) begin
                kg.prime_p = 12'(seq_p[cyc - launch]);
                kg.prime_q = 12'(seq_q[cyc - launch]);
            end else begin
                kg.prime_p = 12'($urandom_range(0, 4095));
                kg.prime_q = 12'($urandom_range(0, 4095));
            end
        end
    end

    task automatic fill_seq(input int p, input int q);
        for (int i = 0; i < 16; i++) begin
            seq_p[i] = p;
            seq_q[i] = q;
        end
    endtask

    task automatic launch_run(input int lp, input int lq, input int ln, input int lt,
                              input int le, input int llat, input bit lerr);
        @(negedge clk);
        model_compute(cyc + 1);
        lit_p = 24'(lp); lit_q = 24'(lq); lit_n = 24'(ln); lit_tot = 24'(lt); lit_e = 24'(le);
        lit_err = lerr;
        lit_cyc = cyc + 1 + llat - 2;
        armed = 1'b1;
        kg.start = 1'b1;
        @(negedge clk);
        kg.start = 1'b0;
    endtask

    task automatic run(input int lp, input int lq, input int ln, input int lt,
                       input int le, input int llat, input bit lerr, input bit poke);
        launch_run(lp, lq, ln, lt, le, llat, lerr);
        while (cyc <= done_cyc_m + 1) begin
            @(negedge clk);
            kg.start = poke && (cyc == launch + 10 || cyc == launch + 50);
        end
        kg.start = 1'b0;
    endtask

    initial begin
        kg.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 61/53: e=3 and e=5 divide 3120, e=7 accepted.
        fill_seq(61, 53);
        run(61, 53, 3233, 3120, 7, 180, 1'b0, 1'b0);

        // Same primes, reset while the Euclid loop is dividing: nothing published, keys cleared.
        fill_seq(61, 53);
        launch_run(61, 53, 3233, 3120, 7, 180, 1'b0);
        while (cyc < launch + 40) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        armed = 1'b0;
        lit_cyc = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Three p==q samples first: same key, three cycles later.
        fill_seq(61, 53);
        for (int i = 0; i < 3; i++) seq_p[i] = 61;
        for (int i = 0; i < 3; i++) seq_q[i] = 61;
        run(61, 53, 3233, 3120, 7, 183, 1'b0, 1'b0);

        // p=2 for every sample: retry limit, err with done, previous key kept.
        fill_seq(2, 7);
        run(61, 53, 3233, 3120, 7, 17, 1'b1, 1'b0);

        // 3/5: totient 8, e=3 after three Euclid divisions; start pulses while busy ignored.
        fill_seq(3, 5);
        run(3, 5, 15, 8, 3, 103, 1'b0, 1'b1);

        // q<3 then p<3 rejected, then 11/13: totient 120, e=7.
        fill_seq(11, 13);
        seq_p[0] = 5; seq_q[0] = 2;
        seq_p[1] = 2; seq_q[1] = 7;
        run(11, 13, 143, 120, 7, 132, 1'b0, 1'b0);

        // 7/11: totient 60, e=3 and e=5 rejected, e=7 after four divisions.
        fill_seq(7, 11);
        run(7, 11, 77, 60, 7, 180, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
